// File: rtl/mix_columns_seq.sv
// mix_columns_seq
//   Column-serial AES MixColumns stage placed directly after shiftRows.
//   A 128-bit state is accepted over a valid/ready handshake. MixColumns is
//   then applied to COLS_PER_CYCLE columns per clock. The result is presented
//   on a valid/ready output toward AddRoundKey. When lastRound is set, the
//   state passes through unchanged, as required for the AES final round.
//
//   Optional feature macro: INV_MIX_COLUMNS_EN
//     When defined, this adds the decrypt port. With decrypt=1 the stage
//     computes InvMixColumns.
//
//   Parameters
//     COLS_PER_CYCLE  columns per clock; legal values are 1, 2 and 4
//
//   Ports
//     clk        rising-edge clock
//     resetN     asynchronous active-low reset
//     inValid    inState/lastRound (and decrypt) valid
//     inReady    block can accept a state (IDLE only)
//     inState    shiftRows output; column c = [127-32c -: 32], row0 in MSB byte
//     lastRound  1 = bypass MixColumns
//     outValid   outState valid, held until outReady
//     outReady   downstream accepts outState
//     outState   result, same byte layout as inState
//     decrypt    (INV_MIX_COLUMNS_EN only) 1 = InvMixColumns
//
//   state | meaning
//   IDLE  | waiting for an input state, inReady=1
//   BUSY  | transforming column groups in the working register
//   DONE  | outValid=1, waiting for the downstream handshake
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         inValid,
  output logic         inReady,
  input  logic [127:0] inState,
  input  logic         lastRound,
  output logic         outValid,
  input  logic         outReady,
  output logic [127:0] outState
`ifdef INV_MIX_COLUMNS_EN
  ,
  input  logic         decrypt
`endif
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : gBadCols
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

  stateT        state;
  logic [1:0]   colCnt;
  logic [127:0] work;
  logic [127:0] nextWork;
  logic         invMode;

  // Multiply by a small GF(2^8) constant, given as a bit mask of {8,4,2,1}.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] coef);
    logic [7:0] x2, x4, x8;
    x2 = {a[6:0], 1'b0}  ^ (a[7]  ? 8'h1b : 8'h00);
    x4 = {x2[6:0], 1'b0} ^ (x2[7] ? 8'h1b : 8'h00);
    x8 = {x4[6:0], 1'b0} ^ (x4[7] ? 8'h1b : 8'h00);
    return (coef[0] ? a  : 8'h00) ^ (coef[1] ? x2 : 8'h00) ^
           (coef[2] ? x4 : 8'h00) ^ (coef[3] ? x8 : 8'h00);
  endfunction

  // One column: b_r = c0*a_r ^ c1*a_(r+1) ^ c2*a_(r+2) ^ c3*a_(r+3).
  function automatic logic [31:0] mixCol(input logic [31:0] col, input logic inv);
    logic [7:0] a0, a1, a2, a3;
    logic [3:0] c0, c1, c2, c3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    c0 = inv ? 4'he : 4'h2;
    c1 = inv ? 4'hb : 4'h3;
    c2 = inv ? 4'hd : 4'h1;
    c3 = inv ? 4'h9 : 4'h1;
    return {gmul(a0, c0) ^ gmul(a1, c1) ^ gmul(a2, c2) ^ gmul(a3, c3),
            gmul(a1, c0) ^ gmul(a2, c1) ^ gmul(a3, c2) ^ gmul(a0, c3),
            gmul(a2, c0) ^ gmul(a3, c1) ^ gmul(a0, c2) ^ gmul(a1, c3),
            gmul(a3, c0) ^ gmul(a0, c1) ^ gmul(a1, c2) ^ gmul(a2, c3)};
  endfunction

  // Transform only the group of columns starting at colCnt.
  always_comb begin
    nextWork = work;
    for (int c = 0; c < 4; c++) begin
      if (c >= int'(colCnt) && c < int'(colCnt) + COLS_PER_CYCLE)
        nextWork[127-32*c -: 32] = mixCol(work[127-32*c -: 32], invMode);
    end
  end

  // inReady is a decode of the state register. It is gated by resetN so that it
  // reads 0 for the whole time reset is asserted.
  assign inReady = resetN && (state == IDLE);

`ifndef INV_MIX_COLUMNS_EN
  assign invMode = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      colCnt   <= 2'd0;
      work     <= 128'h0;
      outValid <= 1'b0;
      outState <= 128'h0;
`ifdef INV_MIX_COLUMNS_EN
      invMode  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (inValid) begin
            work   <= inState;
            colCnt <= 2'd0;
`ifdef INV_MIX_COLUMNS_EN
            invMode <= decrypt;
`endif
            if (lastRound) begin
              outState <= inState;
              outValid <= 1'b1;
              state    <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          work   <= nextWork;
          colCnt <= colCnt + STEP;
          if (colCnt == LAST_CNT) begin
            outState <= nextWork;
            outValid <= 1'b1;
            colCnt   <= 2'd0;
            state    <= DONE;
          end
        end
        DONE: begin
          if (outReady) begin
            outValid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         resetN;
  logic         inValid;
  logic [127:0] inState;
  logic         lastRound;
  logic         outReady;
`ifdef INV_MIX_COLUMNS_EN
  logic         decrypt;
`endif

  logic         ir[3];
  logic         ov[3];
  logic [127:0] os[3];
  int           cpc[3] = '{1, 2, 4};

  int nChecks = 0;
  int nErrors = 0;

  localparam logic [127:0] VEC_A  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] RES_A  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] VEC_B  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] NOISE  = 128'h0123456789abcdef_fedcba9876543210;

  always #5 clk = ~clk;

  mix_columns_seq #(.COLS_PER_CYCLE(1)) u1 (
    .clk(clk), .resetN(resetN), .inValid(inValid), .inReady(ir[0]), .inState(inState),
    .lastRound(lastRound), .outValid(ov[0]), .outReady(outReady), .outState(os[0])
`ifdef INV_MIX_COLUMNS_EN
    , .decrypt(decrypt)
`endif
  );

  mix_columns_seq #(.COLS_PER_CYCLE(2)) u2 (
    .clk(clk), .resetN(resetN), .inValid(inValid), .inReady(ir[1]), .inState(inState),
    .lastRound(lastRound), .outValid(ov[1]), .outReady(outReady), .outState(os[1])
`ifdef INV_MIX_COLUMNS_EN
    , .decrypt(decrypt)
`endif
  );

  mix_columns_seq #(.COLS_PER_CYCLE(4)) u4 (
    .clk(clk), .resetN(resetN), .inValid(inValid), .inReady(ir[2]), .inState(inState),
    .lastRound(lastRound), .outValid(ov[2]), .outReady(outReady), .outState(os[2])
`ifdef INV_MIX_COLUMNS_EN
    , .decrypt(decrypt)
`endif
  );

  task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Accept one state in all three instances. Then measure how many rising edges
  // after the accept edge each outValid takes to appear, and check the data.
  // All instances are left in DONE with outReady low.
  task automatic runVec(input string tag, input logic [127:0] vec, input logic lr,
                        input logic [127:0] exp);
    int lat[3];
    @(negedge clk);
    for (int i = 0; i < 3; i++) checkVal($sformatf("%s_rdy%0d", tag, cpc[i]), 128'(ir[i]), 128'(1));
    inValid   = 1'b1;
    inState   = vec;
    lastRound = lr;
    lat = '{-1, -1, -1};
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin
        inValid = 1'b0;
        inState = NOISE;
      end
      for (int i = 0; i < 3; i++) if (ov[i] && lat[i] < 0) lat[i] = k;
    end
    for (int i = 0; i < 3; i++) begin
      checkVal($sformatf("%s_lat%0d", tag, cpc[i]), 128'(lat[i]), 128'(lr ? 0 : 4 / cpc[i]));
      checkVal($sformatf("%s_data%0d", tag, cpc[i]), os[i], exp);
    end
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    outReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    outReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkVal($sformatf("%s_ovLow%0d", tag, cpc[i]), 128'(ov[i]), 128'(0));
      checkVal($sformatf("%s_idle%0d", tag, cpc[i]), 128'(ir[i]), 128'(1));
    end
  endtask

  initial begin
    resetN    = 1'b0;
    inValid   = 1'b0;
    inState   = 128'h0;
    lastRound = 1'b0;
    outReady  = 1'b0;
`ifdef INV_MIX_COLUMNS_EN
    decrypt   = 1'b0;
`endif

    // Reset values.
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checkVal($sformatf("rst_ov%0d", cpc[i]), 128'(ov[i]), 128'(0));
      checkVal($sformatf("rst_os%0d", cpc[i]), os[i], 128'h0);
      checkVal($sformatf("rst_ir%0d", cpc[i]), 128'(ir[i]), 128'(0));
    end
    resetN = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) checkVal($sformatf("rel_ir%0d", cpc[i]), 128'(ir[i]), 128'(1));

    // Forward MixColumns. outReady is held high here before DONE to show it has no effect.
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    runVec("fwd", VEC_A, 1'b0, RES_A);
    drain("fwd");

    // Final-round bypass.
    runVec("byp", VEC_B, 1'b1, VEC_B);
    drain("byp");

    // Back-pressure in DONE. A new inValid must be ignored.
    runVec("bp", VEC_A, 1'b0, RES_A);
    inValid   = 1'b1;
    inState   = NOISE;
    lastRound = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        checkVal($sformatf("bp_ov%0d", cpc[i]), 128'(ov[i]), 128'(1));
        checkVal($sformatf("bp_os%0d", cpc[i]), os[i], RES_A);
        checkVal($sformatf("bp_ir%0d", cpc[i]), 128'(ir[i]), 128'(0));
      end
    end
    inValid   = 1'b0;
    lastRound = 1'b0;
    drain("bp");
    for (int i = 0; i < 3; i++) checkVal($sformatf("bp_hold%0d", cpc[i]), os[i], RES_A);

    // Reset while the 1-column instance is in BUSY with colCnt=2.
    @(negedge clk);
    inValid = 1'b1;
    inState = VEC_A;
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetN = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkVal($sformatf("mid_ov%0d", cpc[i]), 128'(ov[i]), 128'(0));
      checkVal($sformatf("mid_os%0d", cpc[i]), os[i], 128'h0);
    end
    @(negedge clk);
    resetN = 1'b1;
    runVec("post", VEC_A, 1'b0, RES_A);
    drain("post");

`ifdef INV_MIX_COLUMNS_EN
    decrypt = 1'b1;
    runVec("inv", RES_A, 1'b0, VEC_A);
    drain("inv");
    runVec("invByp", VEC_B, 1'b1, VEC_B);
    drain("invByp");
    decrypt = 1'b0;
    runVec("fwd2", VEC_A, 1'b0, RES_A);
    drain("fwd2");
`endif

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
